usb_hid_key_events: RTL and testbench



---
 rtl/usb_hid_pkg.sv | 48 ++++
 rtl/usb_hid_ev_fifo.sv | 55 +++++
 rtl/usb_hid_key_events.sv | 235 +++++++++++++++++++++++
 tb/tb_usb_hid_key_events.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_hid_pkg.sv
// Shared constants, scan state encoding and key-slot helpers for the USB HID key event stage.
package usb_hid_pkg;

  localparam logic [1:0] TYP_NONE  = 2'd0;
  localparam logic [1:0] TYP_KBD   = 2'd1;
  localparam logic [1:0] TYP_MOUSE = 2'd2;
  localparam logic [1:0] TYP_PAD   = 2'd3;

  localparam int EV_W = 9;

  localparam logic [7:0] MOD_USAGE_BASE   = 8'hE0;
  localparam logic [7:0] HID_ERR_ROLLOVER = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOD    = 3'd1,
    ST_REL    = 3'd2,
    ST_PRS    = 3'd3,
    ST_COMMIT = 3'd4
  } scan_state_t;

  // Slot 0 holds key1 (lowest byte).
  typedef logic [3:0][7:0] key_slots_t;

  function automatic logic key_in_slots(input logic [7:0] key, input key_slots_t slots);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (slots[j] == key) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic key_seen_before(input logic [7:0] key, input key_slots_t slots,
                                           input logic [1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((j < int'(idx)) && (slots[j] == key)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic has_rollover(input key_slots_t slots);
    return key_in_slots(HID_ERR_ROLLOVER, slots);
  endfunction

endpackage

// File: rtl/usb_hid_ev_fifo.sv
// First-word fall-through event FIFO; a pop frees room for a push in the same cycle.
module usb_hid_ev_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head reads as zero when empty so stale RAM contents never leak out.
  assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/usb_hid_key_events.sv
// Keyboard report to press/release event FIFO, plus mouse motion accumulation.
// Mouse accumulators are built only when USB_HID_MOUSE_ACC_EN is defined.
module usb_hid_key_events
  import usb_hid_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ACC_W      = 16
) (
  input  logic                        usbclk,
  input  logic                        usbrst,
  input  logic [1:0]                  typ,
  input  logic                        report,
  input  logic [7:0]                  key_modifiers,
  input  logic [7:0]                  key1,
  input  logic [7:0]                  key2,
  input  logic [7:0]                  key3,
  input  logic [7:0]                  key4,
  input  logic [7:0]                  mouse_btn,
  input  logic [7:0]                  mouse_dx,
  input  logic [7:0]                  mouse_dy,
  input  logic                        ev_rd,
  output logic                        ev_valid,
  output logic [EV_W-1:0]             ev_data,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic                        busy,
  input  logic                        mouse_rd,
  output logic [ACC_W-1:0]            acc_dx,
  output logic [ACC_W-1:0]            acc_dy,
  output logic [7:0]                  acc_btn
);

  scan_state_t state_reg;
  logic [2:0]  idx_reg;
  key_slots_t  nk_reg;
  key_slots_t  pk_reg;
  logic [7:0]  nm_reg;
  logic [7:0]  pm_reg;
  logic [1:0]  typ_prev_reg;
  logic        rel_pend_reg;
  logic        ovf_reg;

  key_slots_t    new_keys;
  logic          kbd_report;
  logic          typ_fall;
  logic          busy_int;
  logic          start_report;
  logic          start_release;
  logic          scan_push;
  logic [EV_W-1:0] scan_ev;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic          ovf_set;
  logic [7:0]    cand;

  assign new_keys   = {key4, key3, key2, key1};
  assign kbd_report = report && (typ == TYP_KBD);
  assign typ_fall   = (typ_prev_reg == TYP_KBD) && (typ != TYP_KBD);
  assign busy_int   = (state_reg != ST_IDLE);

  assign start_report  = kbd_report && !busy_int && !has_rollover(new_keys);
  // A keyboard unplug seen mid-scan is remembered and released once idle.
  assign start_release = !busy_int && !start_report && (typ_fall || rel_pend_reg);

  always_comb begin
    scan_push = 1'b0;
    scan_ev   = '0;
    cand      = '0;
    case (state_reg)
      ST_MOD: begin
        if (nm_reg[idx_reg] != pm_reg[idx_reg]) begin
          scan_push = 1'b1;
          scan_ev   = {nm_reg[idx_reg], MOD_USAGE_BASE + {5'd0, idx_reg}};
        end
      end
      ST_REL: begin
        cand = pk_reg[idx_reg[1:0]];
        if ((cand != 8'h00) && !key_in_slots(cand, nk_reg) &&
            !key_seen_before(cand, pk_reg, idx_reg[1:0])) begin
          scan_push = 1'b1;
          scan_ev   = {1'b0, cand};
        end
      end
      ST_PRS: begin
        cand = nk_reg[idx_reg[1:0]];
        if ((cand != 8'h00) && !key_in_slots(cand, pk_reg) &&
            !key_seen_before(cand, nk_reg, idx_reg[1:0])) begin
          scan_push = 1'b1;
          scan_ev   = {1'b1, cand};
        end
      end
      default: ;
    endcase
  end

  assign fifo_drop = scan_push && fifo_full && !(ev_rd && !fifo_empty);
  assign ovf_set   = fifo_drop || (kbd_report && busy_int);

  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      nk_reg       <= '0;
      pk_reg       <= '0;
      nm_reg       <= '0;
      pm_reg       <= '0;
      typ_prev_reg <= TYP_NONE;
      rel_pend_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      typ_prev_reg <= typ;
      if (ovf_set)      ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
      if (typ_fall && busy_int) rel_pend_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          idx_reg <= '0;
          if (start_report) begin
            nk_reg       <= new_keys;
            nm_reg       <= key_modifiers;
            rel_pend_reg <= 1'b0;
            state_reg    <= ST_MOD;
          end else if (start_release) begin
            nk_reg       <= '0;
            nm_reg       <= '0;
            rel_pend_reg <= 1'b0;
            state_reg    <= ST_MOD;
          end
        end
        ST_MOD: begin
          idx_reg <= idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            idx_reg   <= '0;
            state_reg <= ST_REL;
          end
        end
        ST_REL: begin
          idx_reg <= idx_reg + 3'd1;
          if (idx_reg == 3'd3) begin
            idx_reg   <= '0;
            state_reg <= ST_PRS;
          end
        end
        ST_PRS: begin
          idx_reg <= idx_reg + 3'd1;
          if (idx_reg == 3'd3) begin
            idx_reg   <= '0;
            state_reg <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          pk_reg    <= nk_reg;
          pm_reg    <= nm_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  usb_hid_ev_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (usbclk),
    .srst      (usbrst),
    .push      (scan_push),
    .push_data (scan_ev),
    .pop       (ev_rd),
    .head_data (ev_data),
    .count     (ev_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ovf      = ovf_reg;
  assign busy     = busy_int;

`ifdef USB_HID_MOUSE_ACC_EN
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  logic [ACC_W-1:0] acc_dx_reg;
  logic [ACC_W-1:0] acc_dy_reg;
  logic [7:0]       acc_btn_reg;
  logic             mouse_report;

  // Symmetric saturation: the most negative code is never produced.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [7:0] delta);
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'($signed(delta));
    if (sum > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                    return sum[ACC_W-1:0];
  endfunction

  assign mouse_report = report && (typ == TYP_MOUSE);

  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      acc_dx_reg  <= '0;
      acc_dy_reg  <= '0;
      acc_btn_reg <= '0;
    end else if (mouse_report) begin
      acc_btn_reg <= mouse_btn;
      if (mouse_rd) begin
        acc_dx_reg <= ACC_W'($signed(mouse_dx));
        acc_dy_reg <= ACC_W'($signed(mouse_dy));
      end else begin
        acc_dx_reg <= sat_add(acc_dx_reg, mouse_dx);
        acc_dy_reg <= sat_add(acc_dy_reg, mouse_dy);
      end
    end else if (mouse_rd) begin
      acc_dx_reg <= '0;
      acc_dy_reg <= '0;
    end
  end

  assign acc_dx  = acc_dx_reg;
  assign acc_dy  = acc_dy_reg;
  assign acc_btn = acc_btn_reg;
`else
  logic unused_mouse;
  assign unused_mouse = ^{mouse_btn, mouse_dx, mouse_dy, mouse_rd};
  assign acc_dx  = '0;
  assign acc_dy  = '0;
  assign acc_btn = '0;
`endif

endmodule

// File: tb/tb_usb_hid_key_events.sv
// Scoreboard bench: a set-based key model queues expected events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_usb_hid_key_events;

  localparam int DEPTH = 16;
  localparam int ACC_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          usbclk = 1'b0;
  logic          usbrst = 1'b1;
  logic [1:0]    typ = 2'd1;
  logic          report = 1'b0;
  logic [7:0]    key_modifiers = '0;
  logic [7:0]    key1 = '0, key2 = '0, key3 = '0, key4 = '0;
  logic [7:0]    mouse_btn = '0, mouse_dx = '0, mouse_dy = '0;
  logic          ev_rd;
  logic          ev_valid;
  logic [8:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic          busy;
  logic          mouse_rd = 1'b0;
  logic [ACC_W-1:0] acc_dx, acc_dy;
  logic [7:0]    acc_btn;

  always #5 usbclk = ~usbclk;

  usb_hid_key_events #(.FIFO_DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .usbclk(usbclk), .usbrst(usbrst), .typ(typ), .report(report),
    .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .ev_rd(ev_rd), .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy), .mouse_rd(mouse_rd),
    .acc_dx(acc_dx), .acc_dy(acc_dy), .acc_btn(acc_btn)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [8:0] exp_q[$];
  logic [7:0] mdl_pk[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] mdl_pm = 8'h00;
  bit         mdl_ovf = 1'b0;
  bit         reader_en = 1'b0;
  int         mdl_dx = 0, mdl_dy = 0;
  logic [7:0] mdl_btn = 8'h00;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit in_list(input logic [7:0] v, input logic [7:0] q[$]);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_emit(input logic [8:0] ev);
    if (!reader_en && exp_q.size() >= DEPTH) mdl_ovf = 1'b1;
    else exp_q.push_back(ev);
  endfunction

  // Expected events: modifier bit changes, then released keys, then newly pressed keys.
  function automatic void mdl_report(input logic [7:0] m, input logic [7:0] k[4]);
    logic [7:0] newq[$];
    logic [7:0] oldq[$];
    logic [7:0] seen[$];
    for (int i = 0; i < 4; i++) if (k[i] == 8'h01) return;
    for (int i = 0; i < 4; i++) begin
      newq.push_back(k[i]);
      oldq.push_back(mdl_pk[i]);
    end
    for (int i = 0; i < 8; i++)
      if (m[i] != mdl_pm[i]) mdl_emit({m[i], 8'(8'hE0 + i)});
    foreach (oldq[i]) begin
      if (oldq[i] != 0 && !in_list(oldq[i], newq) && !in_list(oldq[i], seen))
        mdl_emit({1'b0, oldq[i]});
      seen.push_back(oldq[i]);
    end
    seen.delete();
    foreach (newq[i]) begin
      if (newq[i] != 0 && !in_list(newq[i], oldq) && !in_list(newq[i], seen))
        mdl_emit({1'b1, newq[i]});
      seen.push_back(newq[i]);
    end
    for (int i = 0; i < 4; i++) mdl_pk[i] = k[i];
    mdl_pm = m;
  endfunction

  // Monitor: whenever the reader is enabled and the FIFO shows a head, compare and pop it.
  initial begin
    ev_rd = 1'b0;
    forever begin
      @(negedge usbclk);
      ev_rd = 1'b0;
      if (reader_en && !usbrst && ev_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_event: got %03h expected none", ev_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          $display("ev press=%0d usage=%02h", ev_data[8], ev_data[7:0]);
          check("event", ev_data, e);
        end
        ev_rd = 1'b1;
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(negedge usbclk);
      n++;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic send_kbd(input logic [7:0] m, input logic [7:0] a, b, c, d, output int cyc);
    logic [7:0] k[4];
    k = '{a, b, c, d};
    mdl_report(m, k);
    @(negedge usbclk);
    key_modifiers = m; key1 = a; key2 = b; key3 = c; key4 = d; report = 1'b1;
    @(negedge usbclk);
    report = 1'b0;
    wait_idle(cyc);
    $display("kbd mod=%02h keys=%02h %02h %02h %02h busy_cycles=%0d", m, a, b, c, d, cyc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 300) begin
      @(negedge usbclk);
      n++;
    end
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_ev_count", ev_count, 0);
  endtask

  task automatic send_mouse(input logic [7:0] dx, dy, btn, input bit rd);
    @(negedge usbclk);
    mouse_dx = dx; mouse_dy = dy; mouse_btn = btn; report = 1'b1; mouse_rd = rd;
`ifdef USB_HID_MOUSE_ACC_EN
    if (rd) begin
      mdl_dx = int'($signed(dx));
      mdl_dy = int'($signed(dy));
    end else begin
      mdl_dx = mdl_dx + int'($signed(dx));
      mdl_dy = mdl_dy + int'($signed(dy));
      if (mdl_dx > 32767) mdl_dx = 32767;
      if (mdl_dx < -32767) mdl_dx = -32767;
      if (mdl_dy > 32767) mdl_dy = 32767;
      if (mdl_dy < -32767) mdl_dy = -32767;
    end
    mdl_btn = btn;
`endif
    @(negedge usbclk);
    report = 1'b0; mouse_rd = 1'b0;
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_acc_dx"}, longint'($signed(acc_dx)), mdl_dx);
    check({tag, "_acc_dy"}, longint'($signed(acc_dy)), mdl_dy);
    check({tag, "_acc_btn"}, acc_btn, mdl_btn);
  endtask

  initial begin
    int cyc;
    logic [7:0] rk[4];

    repeat (3) @(negedge usbclk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check_acc("rst");
    usbrst = 1'b0;
    @(negedge usbclk);

    // Single key press/release, held in the FIFO before reading.
    send_kbd(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, cyc);
    check("scan_busy_cycles", cyc, 17);
    send_kbd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    check("two_events_count", ev_count, 2);
    check("two_events_valid", ev_valid, 1);
    reader_en = 1'b1;
    wait_drain();

    // Modifier plus overlapping key sets.
    send_kbd(8'h02, 8'h04, 8'h05, 8'h00, 8'h00, cyc);
    send_kbd(8'h00, 8'h05, 8'h06, 8'h00, 8'h00, cyc);
    send_kbd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    wait_drain();

    // ErrorRollOver report is ignored entirely.
    send_kbd(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, cyc);
    send_kbd(8'h00, 8'h01, 8'h04, 8'h00, 8'h00, cyc);
    check("rollover_busy_cycles", cyc, 0);
    send_kbd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    wait_drain();

    // Keyboard disappearing releases held keys without a report pulse.
    send_kbd(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, cyc);
    begin
      logic [7:0] z[4];
      z = '{8'h00, 8'h00, 8'h00, 8'h00};
      mdl_report(8'h00, z);
    end
    @(negedge usbclk); typ = 2'd0;
    @(negedge usbclk);
    wait_idle(cyc);
    check("typ_fall_busy_cycles", cyc, 17);
    typ = 2'd1;
    wait_drain();

    // Randomized reports including duplicates and occasional rollover.
    for (int t = 0; t < 60; t++) begin
      for (int s = 0; s < 4; s++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 6)       rk[s] = 8'h00;
        else if (r == 19) rk[s] = 8'h01;
        else             rk[s] = 8'(8'h04 + (r - 6) % 8);
      end
      send_kbd(8'($urandom_range(0, 255)), rk[0], rk[1], rk[2], rk[3], cyc);
    end
    send_kbd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    wait_drain();
    check("random_no_ovf", ovf, 0);

    // Fill the FIFO exactly, then overflow it.
    reader_en = 1'b0;
    send_kbd(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    send_kbd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, cyc);
    check("full_count", ev_count, DEPTH);
    check("full_no_ovf", ovf, 0);
    send_kbd(8'h00, 8'h04, 8'h05, 8'h00, 8'h00, cyc);
    check("drop_ovf", ovf, mdl_ovf);
    check("drop_count", ev_count, DEPTH);
    @(negedge usbclk); ovf_clr = 1'b1;
    @(negedge usbclk); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);
    reader_en = 1'b1;
    wait_drain();

    // Report arriving while a scan is running is dropped and flagged.
    begin
      logic [7:0] z[4];
      z = '{8'h00, 8'h00, 8'h00, 8'h00};
      mdl_report(8'h00, z);
    end
    @(negedge usbclk);
    key_modifiers = 8'h00; key1 = 8'h00; key2 = 8'h00; key3 = 8'h00; key4 = 8'h00; report = 1'b1;
    @(negedge usbclk); report = 1'b0;
    @(negedge usbclk); key1 = 8'h07; report = 1'b1;
    @(negedge usbclk); report = 1'b0; key1 = 8'h00;
    wait_idle(cyc);
    check("busy_report_ovf", ovf, 1);
    @(negedge usbclk); ovf_clr = 1'b1;
    @(negedge usbclk); ovf_clr = 1'b0;
    wait_drain();

    // Mouse accumulation.
    @(negedge usbclk); typ = 2'd2;
    @(negedge usbclk);
    wait_idle(cyc);
    for (int t = 0; t < 300; t++) send_mouse(8'd127, 8'($urandom_range(0, 255)), 8'h05, 1'b0);
    check_acc("mouse_sat");
    send_mouse(8'hFB, 8'h03, 8'h02, 1'b1);
    check_acc("mouse_rd_report");
    @(negedge usbclk); mouse_rd = 1'b1;
    @(negedge usbclk); mouse_rd = 1'b0;
`ifdef USB_HID_MOUSE_ACC_EN
    mdl_dx = 0; mdl_dy = 0;
`endif
    check_acc("mouse_clear");
    for (int t = 0; t < 20; t++) begin
      send_mouse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), bit'($urandom_range(0, 3) == 0));
      $display("mouse acc_dx=%0d acc_dy=%0d", $signed(acc_dx), $signed(acc_dy));
      check_acc("mouse_rand");
    end
    check("mouse_no_events", ev_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
